// File: rtl/delta_accumulator_pkg.sv
// Shared types and defaults for the delta accumulator: output-buffer states and widths.
package delta_accumulator_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefCntWidth  = 16;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/delta_accumulator_if.sv
// Input delta stream and output sample stream of the delta accumulator.
interface delta_accumulator_if #(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned CNTWIDTH  = 16
);

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_first;
  logic [DATAWIDTH-1:0] in_delta;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_sample;
  logic                 out_first;
  logic [CNTWIDTH-1:0]  sample_count;
  logic                 err_nofirst;

  modport master (
    output in_valid, in_first, in_delta, out_ready,
    input  in_ready, out_valid, out_sample, out_first, sample_count, err_nofirst
  );

  modport slave (
    input  in_valid, in_first, in_delta, out_ready,
    output in_ready, out_valid, out_sample, out_first, sample_count, err_nofirst
  );

endinterface

// File: rtl/delta_accumulator_add.sv
// Combinational wrapping adder, companion to the differencing subtractor.
module delta_accumulator_add #(
  parameter int unsigned DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/delta_accumulator.sv
// Rebuilds absolute samples from a delta stream; 1-cycle latency, 2-entry skid output buffer.
module delta_accumulator
  import delta_accumulator_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DefDataWidth,
  parameter int unsigned CNTWIDTH  = DefCntWidth
) (
  input logic                Clk,
  input logic                Rst,
  delta_accumulator_if.slave bus
);

  buf_state_e           state_q;
  logic [DATAWIDTH-1:0] acc_q;
  logic [CNTWIDTH-1:0]  cnt_q;
  logic                 seen_first_q;
  logic                 err_q;
  logic                 out_valid_q;
  logic [DATAWIDTH-1:0] main_sample_q, skid_sample_q;
  logic                 main_first_q, skid_first_q;
  logic [CNTWIDTH-1:0]  main_cnt_q, skid_cnt_q;

  logic [DATAWIDTH-1:0] sum;
  logic [DATAWIDTH-1:0] acc_d;
  logic [CNTWIDTH-1:0]  cnt_d;
  logic                 accept;
  logic                 consume;

  delta_accumulator_add #(
    .DATAWIDTH(DATAWIDTH)
  ) u_add (
    .a  (acc_q),
    .b  (bus.in_delta),
    .sum(sum)
  );

  // in_ready depends only on state, never on out_ready.
  assign bus.in_ready = (state_q != StTwo) & ~Rst;
  assign accept       = bus.in_valid & bus.in_ready;
  assign consume      = out_valid_q & bus.out_ready;

  always_comb begin
    acc_d = sum;
    cnt_d = cnt_q + 1'b1;
    if (bus.in_first) begin
      acc_d = bus.in_delta;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= StEmpty;
      acc_q         <= '0;
      cnt_q         <= '0;
      seen_first_q  <= 1'b0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      main_sample_q <= '0;
      main_first_q  <= 1'b0;
      main_cnt_q    <= '0;
      skid_sample_q <= '0;
      skid_first_q  <= 1'b0;
      skid_cnt_q    <= '0;
    end else begin
      if (accept) begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        if (bus.in_first) begin
          seen_first_q <= 1'b1;
        end else if (!seen_first_q) begin
          err_q <= 1'b1;
        end
      end
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_sample_q <= acc_d;
            main_first_q  <= bus.in_first;
            main_cnt_q    <= cnt_d;
            out_valid_q   <= 1'b1;
            state_q       <= StOne;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_sample_q <= acc_d;
            main_first_q  <= bus.in_first;
            main_cnt_q    <= cnt_d;
          end else if (consume) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end else if (accept) begin
            skid_sample_q <= acc_d;
            skid_first_q  <= bus.in_first;
            skid_cnt_q    <= cnt_d;
            state_q       <= StTwo;
          end
        end
        StTwo: begin
          if (consume) begin
            main_sample_q <= skid_sample_q;
            main_first_q  <= skid_first_q;
            main_cnt_q    <= skid_cnt_q;
            state_q       <= StOne;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StEmpty;
        end
      endcase
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sample   = main_sample_q;
  assign bus.out_first    = main_first_q;
  assign bus.sample_count = main_cnt_q;
  assign bus.err_nofirst  = err_q;

endmodule

// File: tb/tb_delta_accumulator.sv
// Scoreboard bench for delta_accumulator: random and directed delta streams vs a reference model.
module tb_delta_accumulator;

  typedef struct packed {
    logic [63:0] s;
    logic        f;
    logic [15:0] c;
    logic        e;
  } exp_t;

  typedef struct {
    logic [63:0] s;
    logic        f;
    logic [15:0] c;
    int          cyc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   rmode = 1;  // 0: out_ready low, 1: high, 2: random

  exp_t exp_q[$];
  obs_t obs_q[$];

  // Reference model state
  logic [63:0] m_acc  = '0;
  logic [15:0] m_cnt  = '0;
  logic        m_seen = 1'b0;
  logic        m_err  = 1'b0;

  delta_accumulator_if #(.DATAWIDTH(64), .CNTWIDTH(16)) bus ();

  delta_accumulator #(
    .DATAWIDTH(64),
    .CNTWIDTH (16)
  ) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc  = '0;
    m_cnt  = '0;
    m_seen = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_accept(input logic f, input logic [63:0] d);
    exp_t e;
    if (f) begin
      m_acc  = d;
      m_cnt  = '0;
      m_seen = 1'b1;
    end else begin
      if (!m_seen) m_err = 1'b1;
      m_acc = m_acc + d;
      m_cnt = m_cnt + 16'd1;
    end
    e.s = m_acc;
    e.f = f;
    e.c = m_cnt;
    e.e = m_err;
    exp_q.push_back(e);
    n_acc++;
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send(input logic f, input logic [63:0] d);
    int  n    = 0;
    bit  done = 0;
    bus.in_valid = 1'b1;
    bus.in_first = f;
    bus.in_delta = d;
    while (!done) begin
      #4;
      if (bus.in_ready) begin
        model_accept(f, d);
        done = 1;
      end else if (n > 200) begin
        chk("send_timeout", 64'd0, 64'd1);
        done = 1;
      end
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each consumed output, checks stability under backpressure.
  initial begin
    bit          hold = 0;
    logic [63:0] hs;
    logic        hf;
    logic [15:0] hc;
    exp_t        e;
    obs_t        o;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", 64'(bus.out_valid), 64'd1);
          chk("hold_sample", bus.out_sample, hs);
          chk("hold_first", 64'(bus.out_first), 64'(hf));
          chk("hold_count", 64'(bus.sample_count), 64'(hc));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sample", bus.out_sample, e.s);
            chk("first", 64'(bus.out_first), 64'(e.f));
            chk("count", 64'(bus.sample_count), 64'(e.c));
            chk("err_nofirst", 64'(bus.err_nofirst), 64'(e.e));
          end
          o.s   = bus.out_sample;
          o.f   = bus.out_first;
          o.c   = bus.sample_count;
          o.cyc = cyc;
          obs_q.push_back(o);
        end
        hold = bus.out_valid && !bus.out_ready;
        hs   = bus.out_sample;
        hf   = bus.out_first;
        hc   = bus.sample_count;
      end
    end
  end

  initial begin
    logic [63:0] exp_bp[8];
    logic [63:0] exp_fr[5];
    logic [15:0] cnt_fr[5];
    logic [63:0] d;
    int          gap;
    bit          bp_done;
    int          n;

    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_delta = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sample", bus.out_sample, 64'd0);
    chk("rst_count", 64'(bus.sample_count), 64'd0);
    chk("rst_err", 64'(bus.err_nofirst), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic stream at full throughput
    rmode = 1;
    @(negedge clk);
    obs_q.delete();
    send(1'b1, 64'd100);
    send(1'b0, 64'd5);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    send(1'b0, 64'd10);
    drain();
    chk("basic_n", 64'(obs_q.size()), 64'd4);
    if (obs_q.size() == 4) begin
      chk("basic_s0", obs_q[0].s, 64'd100);
      chk("basic_s1", obs_q[1].s, 64'd105);
      chk("basic_s2", obs_q[2].s, 64'd102);
      chk("basic_s3", obs_q[3].s, 64'd112);
      chk("basic_f0", 64'(obs_q[0].f), 64'd1);
      chk("basic_f3", 64'(obs_q[3].f), 64'd0);
      chk("basic_c3", 64'(obs_q[3].c), 64'd3);
      chk("basic_rate", 64'(obs_q[3].cyc - obs_q[0].cyc), 64'd3);
    end

    // Wrap-around
    obs_q.delete();
    send(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    send(1'b0, 64'd5);
    send(1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
    drain();
    if (obs_q.size() == 3) begin
      chk("wrap_s1", obs_q[1].s, 64'd3);
      chk("wrap_s2", obs_q[2].s, 64'hFFFF_FFFF_FFFF_FFFF);
    end else chk("wrap_n", 64'(obs_q.size()), 64'd3);
    chk("wrap_err", 64'(bus.err_nofirst), 64'd0);

    // Frame restart
    exp_fr = '{64'd10, 64'd11, 64'd12, 64'd50, 64'd52};
    cnt_fr = '{16'd0, 16'd1, 16'd2, 16'd0, 16'd1};
    obs_q.delete();
    send(1'b1, 64'd10);
    send(1'b0, 64'd1);
    send(1'b0, 64'd1);
    send(1'b1, 64'd50);
    send(1'b0, 64'd2);
    drain();
    chk("frame_n", 64'(obs_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      chk("frame_s", obs_q[i].s, exp_fr[i]);
      chk("frame_c", 64'(obs_q[i].c), 64'(cnt_fr[i]));
    end

    // Backpressure: out_ready low for 3 cycles while 8 samples are offered
    exp_bp = '{64'd1000, 64'd1001, 64'd1003, 64'd1006, 64'd1010, 64'd1015, 64'd1021,
               64'd1028};
    rmode = 0;
    @(negedge clk);
    obs_q.delete();
    n_acc   = 0;
    bp_done = 0;
    fork
      begin
        send(1'b1, 64'd1000);
        for (int i = 1; i < 8; i++) send(1'b0, 64'(i));
        bp_done = 1;
      end
    join_none
    repeat (3) @(negedge clk);
    #4;
    chk("bp_accepts", 64'(n_acc), 64'd2);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_held", bus.out_sample, 64'd1000);
    rmode = 1;
    n = 0;
    while (!bp_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_done", 64'(bp_done), 64'd1);
    drain();
    chk("bp_n", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8 && i < obs_q.size(); i++) chk("bp_s", obs_q[i].s, exp_bp[i]);

    // Random traffic with random backpressure
    rmode = 2;
    @(negedge clk);
    send(1'b1, {$urandom, $urandom});
    for (int i = 0; i < 400; i++) begin
      gap = $urandom_range(0, 3);
      if (gap == 3) @(negedge clk);
      d = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
      send($urandom_range(0, 7) == 0, d);
    end
    drain();

    // Delta without a preceding frame start
    rmode = 1;
    do_reset();
    @(negedge clk);
    obs_q.delete();
    send(1'b0, 64'd7);
    drain();
    if (obs_q.size() == 1) chk("nofirst_s", obs_q[0].s, 64'd7);
    else chk("nofirst_n", 64'(obs_q.size()), 64'd1);
    chk("nofirst_err", 64'(bus.err_nofirst), 64'd1);
    send(1'b1, 64'd1);
    send(1'b0, 64'd2);
    drain();
    chk("nofirst_sticky", 64'(bus.err_nofirst), 64'd1);

    // Reset while the buffer is full
    do_reset();
    rmode = 0;
    @(negedge clk);
    send(1'b1, 64'd1);
    send(1'b0, 64'd2);
    #1;
    chk("two_in_ready", 64'(bus.in_ready), 64'd0);
    chk("two_out_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_sample", bus.out_sample, 64'd0);
    chk("mid_rst_first", 64'(bus.out_first), 64'd0);
    chk("mid_rst_count", 64'(bus.sample_count), 64'd0);
    chk("mid_rst_err", 64'(bus.err_nofirst), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rmode = 1;
    @(negedge clk);
    obs_q.delete();
    send(1'b1, 64'd9);
    drain();
    chk("post_rst_n", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) begin
      chk("post_rst_s", obs_q[0].s, 64'd9);
      chk("post_rst_c", 64'(obs_q[0].c), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
